snow64_bfloat16_vector_slt: RTL and testbench
=============================================

Name: snow64_bfloat16_vector_slt

Overview:
Multi-cycle vector compare stage. It takes two 256-bit operands, each holding 16 BFloat16 lanes, and feeds lane pairs to a bank of single-cycle scalar BFloat16 "less than" comparators. It collects their 1-bit results into a per-lane integer result vector and a 16-bit mask. It sits in the vector ALU between operand read and writeback, using a start / data_valid / can_accept_cmd handshake.

Parameters:
LANES_PER_CYCLE, 4, lanes compared per cycle; legal values 1, 2, 4, 8, 16; other values fail elaboration.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
in_start  input  1  command strobe; accepted only when out_can_accept_cmd=1
in_op  input  1  0=SLT (a<b), 1=SGT (a>b, implemented as b<a)
in_a  input  256  operand A; lane i = bits [16i+15:16i]
in_b  input  256  operand B, same layout
out_can_accept_cmd  output  1  high iff state=IDLE
out_data_valid  output  1  one-cycle pulse; result is ready
out_data  output  256  lane i = 16'h0001 if compare true, else 16'h0000
out_mask  output  16  bit i = compare result of lane i

Behaviour:
- Reset (synchronous, rst wins over everything): state=IDLE, lane counter=0, out_data_valid=0, out_data=0, out_mask=0, out_can_accept_cmd=1.
- IDLE: on a clock edge with in_start=1:
  - register a/b, swapping them if in_op=1;
  - clear the internal accumulator, set counter=0;
  - go to BUSY.
- BUSY: each cycle, lanes [counter*L +: L] go to L comparator instances.
  - Results are written into the accumulator at the edge and the counter increments.
  - On the edge that writes the final chunk (counter = 16/L - 1):
    - copy the accumulator (including the final chunk) to out_data/out_mask;
    - set out_data_valid=1 and go to IDLE.
- Latency: start accepted at edge E0; out_data_valid is high in the cycle following edge E(16/L). With L=4 that is 4 cycles after acceptance, giving throughput 1 command per 16/L+1 cycles.
- out_data_valid deasserts on the next edge unconditionally.
- out_data/out_mask hold their value until the next command completes. They never show partial results.
- in_start while BUSY is ignored, with no queueing.
- in_start in the out_data_valid cycle is accepted, because state is IDLE there.
- Compare semantics per lane (sign-magnitude):
  - both signs 0: a_mag < b_mag;
  - a sign 0, b sign 1: false;
  - a sign 1, b sign 0: true unless both magnitudes are zero (so -0 < +0 is false);
  - both signs 1: b_mag < a_mag.
- Operands change in IDLE without effect. Operands are not re-sampled while BUSY.
- Reset asserted mid-BUSY: abort and return to the reset values above. No out_data_valid is produced for the aborted command.

Optional Feature:
SNOW64_BFLOAT16_VECTOR_SLT_NAN_CHECK_EN
- Defined: a lane whose a or b is NaN (exp=8'hFF, mantissa≠0) yields 0 regardless of the sign rules.
- Undefined: no NaN detection; NaNs are compared by the sign/magnitude rules above.
- Latency is identical either way.

Decomposition:
- PkgSnow64BFloat16 gains:
  - constants WIDTH__SNOW64_BFLOAT16_VECTOR=256 and NUM_SNOW64_BFLOAT16_LANES=16;
  - enum CmpOp {CmpOpSlt, CmpOpSgt};
  - structs PortIn_VecCmp {start, op, a, b} and PortOut_VecCmp {can_accept_cmd, data_valid, data, mask};
  - state enum {StIdle, StBusy}.
- Sub-module: L instances of the existing scalar Snow64BFloat16Slt comparator, one per lane slot. The NaN-check gating lives in this block, not in the comparator.

Test Plan:
1. L=4; all lanes a=0x3F80 (1.0), b=0x4000 (2.0), SLT -> out_data_valid exactly 4 cycles after acceptance; mask=16'hFFFF; every lane 16'h0001.
2. All lanes a=0x0000, b=0x8000, then a=0x8000, b=0x0000, SLT -> mask=16'h0000 both times; 1.0 vs 1.0 -> mask 16'h0000.
3. Even lanes a=0xBF80 (-1.0), b=0x3F80; odd lanes a=0x4000, b=0x3F80 -> SLT mask=16'h5555; SGT mask=16'hAAAA.
4. rst pulsed in the 2nd BUSY cycle -> no data_valid; out_data=0, mask=0, can_accept=1 next cycle; a following command completes normally.
5. in_start held during BUSY -> ignored. New start in the data_valid cycle -> accepted; out_mask keeps the first result until the second completes.
6. Lane 0: a=0xFFC0 (NaN), b=0x3F80 -> mask bit0=0 with NAN_CHECK_EN defined, 1 without; repeat the sweep for L=1, 2, 8, 16 to check latency = 16/L.

Source files
------------

// File: rtl/snow64_bfloat16_vector_slt_pkg.sv
// Shared types and constants for the 16-lane BFloat16 vector compare stage.
package snow64_bfloat16_vector_slt_pkg;

    localparam int WIDTH__SNOW64_BFLOAT16 = 16;
    localparam int WIDTH__SNOW64_BFLOAT16_VECTOR = 256;
    localparam int NUM_SNOW64_BFLOAT16_LANES = 16;

    typedef enum logic {
        CmpOpSlt = 1'b0,
        CmpOpSgt = 1'b1
    } CmpOp;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } VecCmpState;

    typedef struct packed {
        logic                                     start;
        CmpOp                                     op;
        logic [WIDTH__SNOW64_BFLOAT16_VECTOR-1:0] a;
        logic [WIDTH__SNOW64_BFLOAT16_VECTOR-1:0] b;
    } PortIn_VecCmp;

    typedef struct packed {
        logic                                     can_accept_cmd;
        logic                                     data_valid;
        logic [WIDTH__SNOW64_BFLOAT16_VECTOR-1:0] data;
        logic [NUM_SNOW64_BFLOAT16_LANES-1:0]     mask;
    } PortOut_VecCmp;

    function automatic logic bf16_is_nan(input logic [15:0] x);
        return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
    endfunction

endpackage

// File: rtl/Snow64BFloat16Slt.sv
// Single-cycle scalar BFloat16 a < b comparator using sign-magnitude ordering.
module Snow64BFloat16Slt (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic        lt_o
);

    logic        sign_a;
    logic        sign_b;
    logic [14:0] mag_a;
    logic [14:0] mag_b;

    assign sign_a = a_i[15];
    assign sign_b = b_i[15];
    assign mag_a  = a_i[14:0];
    assign mag_b  = b_i[14:0];

    always_comb begin
        lt_o = 1'b0;
        case ({sign_a, sign_b})
            2'b00: lt_o = mag_a < mag_b;
            2'b01: lt_o = 1'b0;
            // -0 and +0 compare equal, so they are not ordered.
            2'b10: lt_o = (mag_a != 15'd0) || (mag_b != 15'd0);
            2'b11: lt_o = mag_b < mag_a;
            default: lt_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/snow64_bfloat16_vector_slt.sv
// Multi-cycle 16-lane BFloat16 SLT/SGT stage, LANES_PER_CYCLE lanes per cycle.
// Optional NaN gating: define SNOW64_BFLOAT16_VECTOR_SLT_NAN_CHECK_EN.
module snow64_bfloat16_vector_slt
    import snow64_bfloat16_vector_slt_pkg::*;
#(
    parameter int LANES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_start,
    input  logic         in_op,
    input  logic [255:0] in_a,
    input  logic [255:0] in_b,
    output logic         out_can_accept_cmd,
    output logic         out_data_valid,
    output logic [255:0] out_data,
    output logic [15:0]  out_mask
);

    localparam int L       = LANES_PER_CYCLE;
    localparam int CHUNK_W = L * WIDTH__SNOW64_BFLOAT16;
    localparam logic [3:0] CNT_LAST = 4'(NUM_SNOW64_BFLOAT16_LANES / L - 1);

    if (!(L == 1 || L == 2 || L == 4 || L == 8 || L == 16)) begin : g_bad_lanes
        $error("LANES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    PortIn_VecCmp  port_in;
    PortOut_VecCmp port_out;

    VecCmpState    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [255:0]  a_q, a_d;
    logic [255:0]  b_q, b_d;
    logic [15:0]   acc_q, acc_d;
    logic [15:0]   mask_q, mask_d;
    logic          valid_q, valid_d;

    logic [CHUNK_W-1:0] a_chunk;
    logic [CHUNK_W-1:0] b_chunk;
    logic [L-1:0]       lane_lt;
    logic [L-1:0]       lane_res;

    always_comb begin
        port_in.start = in_start;
        port_in.op    = CmpOp'(in_op);
        port_in.a     = in_a;
        port_in.b     = in_b;
    end

    assign a_chunk = a_q[cnt_q*CHUNK_W +: CHUNK_W];
    assign b_chunk = b_q[cnt_q*CHUNK_W +: CHUNK_W];

    for (genvar li = 0; li < L; li++) begin : g_lane
        logic [15:0] lane_a;
        logic [15:0] lane_b;

        assign lane_a = a_chunk[li*16 +: 16];
        assign lane_b = b_chunk[li*16 +: 16];

        Snow64BFloat16Slt u_slt (
            .a_i  (lane_a),
            .b_i  (lane_b),
            .lt_o (lane_lt[li])
        );

`ifdef SNOW64_BFLOAT16_VECTOR_SLT_NAN_CHECK_EN
        // Any NaN operand makes the lane unordered, hence false.
        assign lane_res[li] = lane_lt[li] & ~(bf16_is_nan(lane_a) | bf16_is_nan(lane_b));
`else
        assign lane_res[li] = lane_lt[li];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            mask_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        mask_d  = mask_q;
        valid_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (port_in.start) begin
                    // SGT is evaluated as b < a by swapping at capture time.
                    if (port_in.op == CmpOpSgt) begin
                        a_d = port_in.b;
                        b_d = port_in.a;
                    end else begin
                        a_d = port_in.a;
                        b_d = port_in.b;
                    end
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                acc_d[cnt_q*L +: L] = lane_res;
                if (cnt_q == CNT_LAST) begin
                    mask_d  = acc_d;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        port_out.can_accept_cmd = (state_q == StIdle);
        port_out.data_valid     = valid_q;
        port_out.mask           = mask_q;
        port_out.data           = '0;
        for (int i = 0; i < NUM_SNOW64_BFLOAT16_LANES; i++) begin
            port_out.data[i*16] = mask_q[i];
        end
    end

    assign out_can_accept_cmd = port_out.can_accept_cmd;
    assign out_data_valid     = port_out.data_valid;
    assign out_data           = port_out.data;
    assign out_mask           = port_out.mask;

endmodule

// File: tb/tb_snow64_bfloat16_vector_slt.sv
// Directed bench for snow64_bfloat16_vector_slt: main L=4 instance plus L=1/2/8/16 latency sweep.
module tb_snow64_bfloat16_vector_slt;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_start;
    logic         in_op;
    logic [255:0] in_a;
    logic [255:0] in_b;

    logic         can;
    logic         valid;
    logic [255:0] data;
    logic [15:0]  mask;

    logic         sw_can   [4];
    logic         sw_valid [4];
    logic [255:0] sw_data  [4];
    logic [15:0]  sw_mask  [4];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    snow64_bfloat16_vector_slt #(.LANES_PER_CYCLE(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .in_start           (in_start),
        .in_op              (in_op),
        .in_a               (in_a),
        .in_b               (in_b),
        .out_can_accept_cmd (can),
        .out_data_valid     (valid),
        .out_data           (data),
        .out_mask           (mask)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
        localparam int LV = 1 << ((gi < 2) ? gi : gi + 1);
        snow64_bfloat16_vector_slt #(.LANES_PER_CYCLE(LV)) u_sw (
            .clk                (clk),
            .rst                (rst),
            .in_start           (in_start),
            .in_op              (in_op),
            .in_a               (in_a),
            .in_b               (in_b),
            .out_can_accept_cmd (sw_can[gi]),
            .out_data_valid     (sw_valid[gi]),
            .out_data           (sw_data[gi]),
            .out_mask           (sw_mask[gi])
        );
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] expand(input logic [15:0] m);
        logic [255:0] r = '0;
        for (int i = 0; i < 16; i++) r[i*16] = m[i];
        return r;
    endfunction

    function automatic logic [255:0] fill(input logic [15:0] ev, input logic [15:0] od);
        logic [255:0] r;
        for (int i = 0; i < 16; i++) r[i*16 +: 16] = (i % 2 == 0) ? ev : od;
        return r;
    endfunction

    task automatic drive_cmd(input logic [255:0] a, input logic [255:0] b, input logic op);
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_start = 1'b0;
    endtask

    // Called at the negedge after the accepting edge; counts edges until valid.
    task automatic wait_valid(output int n);
        n = 0;
        while (n <= 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (valid) break;
        end
    endtask

    task automatic run_cmd(input string tag, input logic [255:0] a, input logic [255:0] b,
                           input logic op, input logic [15:0] exp_mask);
        int n;
        drive_cmd(a, b, op);
        check({tag, "_busy_can"}, 256'(can), 256'(1'b0));
        wait_valid(n);
        check({tag, "_latency"}, 256'(n), 256'(4));
        check({tag, "_mask"}, 256'(mask), 256'(exp_mask));
        check({tag, "_data"}, data, expand(exp_mask));
        @(negedge clk);
        check({tag, "_valid_drop"}, 256'(valid), 256'(1'b0));
        check({tag, "_idle_can"}, 256'(can), 256'(1'b1));
    endtask

    initial begin
        logic [255:0] a6;
        logic [255:0] b6;
        logic [15:0]  exp6;
        int           n;
        int           lat_main;
        int           lat_sw [4];
        logic         seen;

        rst = 1'b1; in_start = 1'b0; in_op = 1'b0; in_a = '0; in_b = '0;
        repeat (3) @(negedge clk);
        check("rst_can", 256'(can), 256'(1'b1));
        check("rst_valid", 256'(valid), 256'(1'b0));
        check("rst_mask", 256'(mask), 256'(16'h0000));
        check("rst_data", data, 256'(0));
        rst = 1'b0;

        run_cmd("t1_lt", fill(16'h3F80, 16'h3F80), fill(16'h4000, 16'h4000), 1'b0, 16'hFFFF);
        run_cmd("t2_pz_nz", fill(16'h0000, 16'h0000), fill(16'h8000, 16'h8000), 1'b0, 16'h0000);
        run_cmd("t2_nz_pz", fill(16'h8000, 16'h8000), fill(16'h0000, 16'h0000), 1'b0, 16'h0000);
        run_cmd("t2_eq", fill(16'h3F80, 16'h3F80), fill(16'h3F80, 16'h3F80), 1'b0, 16'h0000);
        run_cmd("t3_neg", fill(16'hC000, 16'hBF80), fill(16'hBF80, 16'hC000), 1'b0, 16'h5555);
        run_cmd("t3_slt", fill(16'hBF80, 16'h4000), fill(16'h3F80, 16'h3F80), 1'b0, 16'h5555);
        run_cmd("t3_sgt", fill(16'hBF80, 16'h4000), fill(16'h3F80, 16'h3F80), 1'b1, 16'hAAAA);

        // Reset during the second busy cycle aborts the command.
        drive_cmd(fill(16'h3F80, 16'h3F80), fill(16'h4000, 16'h4000), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_valid", 256'(valid), 256'(1'b0));
        check("t4_mask", 256'(mask), 256'(16'h0000));
        check("t4_data", data, 256'(0));
        check("t4_can", 256'(can), 256'(1'b1));
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | valid;
        end
        check("t4_no_valid", 256'(seen), 256'(1'b0));
        run_cmd("t4_after", fill(16'hBF80, 16'h4000), fill(16'h3F80, 16'h3F80), 1'b0, 16'h5555);

        // Held start during BUSY, then back-to-back accept in the valid cycle.
        @(negedge clk);
        in_a = fill(16'h3F80, 16'h3F80); in_b = fill(16'h4000, 16'h4000);
        in_op = 1'b0; in_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5_busy_can", 256'(can), 256'(1'b0));
        in_a = fill(16'hBF80, 16'h4000); in_b = fill(16'h3F80, 16'h3F80);
        wait_valid(n);
        check("t5_lat1", 256'(n), 256'(4));
        check("t5_mask1", 256'(mask), 256'(16'hFFFF));
        @(posedge clk);
        @(negedge clk);
        in_start = 1'b0;
        check("t5_valid_drop", 256'(valid), 256'(1'b0));
        check("t5_accepted", 256'(can), 256'(1'b0));
        check("t5_mask_hold", 256'(mask), 256'(16'hFFFF));
        wait_valid(n);
        check("t5_lat2", 256'(n), 256'(4));
        check("t5_mask2", 256'(mask), 256'(16'h5555));
        check("t5_data2", data, expand(16'h5555));

        // NaN lane plus latency sweep across all lane widths.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a6 = fill(16'h3F80, 16'h3F80); a6[15:0] = 16'hFFC0;
        b6 = fill(16'h4000, 16'h4000); b6[15:0] = 16'h3F80;
`ifdef SNOW64_BFLOAT16_VECTOR_SLT_NAN_CHECK_EN
        exp6 = 16'hFFFE;
`else
        exp6 = 16'hFFFF;
`endif
        drive_cmd(a6, b6, 1'b0);
        lat_main = -1;
        for (int k = 0; k < 4; k++) lat_sw[k] = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid && lat_main < 0) lat_main = c;
            for (int k = 0; k < 4; k++)
                if (sw_valid[k] && lat_sw[k] < 0) lat_sw[k] = c;
        end
        check("t6_lat_l4", 256'(lat_main), 256'(4));
        check("t6_mask_l4", 256'(mask), 256'(exp6));
        for (int k = 0; k < 4; k++) begin
            int lv;
            lv = 1 << ((k < 2) ? k : k + 1);
            check($sformatf("t6_lat_l%0d", lv), 256'(lat_sw[k]), 256'(16 / lv));
            check($sformatf("t6_mask_l%0d", lv), 256'(sw_mask[k]), 256'(exp6));
            check($sformatf("t6_data_l%0d", lv), sw_data[k], expand(exp6));
            check($sformatf("t6_can_l%0d", lv), 256'(sw_can[k]), 256'(1'b1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
